// File: rtl/hub75_row_driver_pkg.sv
// Shared types for the LED display path: row-pair payload, panel geometry and driver state encoding.
package led_display_package;

    localparam int GL_NUM_COL_PIXELS = 64;
    localparam int GL_NUM_ROWS       = 16;

    typedef struct packed {
        logic [GL_NUM_COL_PIXELS-1:0] red;
        logic [GL_NUM_COL_PIXELS-1:0] green;
        logic [GL_NUM_COL_PIXELS-1:0] blue;
    } rgb_half_t;

    typedef struct packed {
        rgb_half_t top;
        rgb_half_t bottom;
    } rgb_row_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_WAIT_DISP,
        ST_BLANK_PRE,
        ST_LATCH,
        ST_BLANK_POST
    } hub75_state_t;

    // Advance every colour plane by one pixel; the next pixel lands in the MSB.
    function automatic rgb_row_t row_shift_left(input rgb_row_t r);
        rgb_row_t s;
        s.top.red      = {r.top.red[GL_NUM_COL_PIXELS-2:0], 1'b0};
        s.top.green    = {r.top.green[GL_NUM_COL_PIXELS-2:0], 1'b0};
        s.top.blue     = {r.top.blue[GL_NUM_COL_PIXELS-2:0], 1'b0};
        s.bottom.red   = {r.bottom.red[GL_NUM_COL_PIXELS-2:0], 1'b0};
        s.bottom.green = {r.bottom.green[GL_NUM_COL_PIXELS-2:0], 1'b0};
        s.bottom.blue  = {r.bottom.blue[GL_NUM_COL_PIXELS-2:0], 1'b0};
        return s;
    endfunction

endpackage

// File: rtl/hub75_row_driver_if.sv
// Row-pair handshake between the pattern generators (master) and the HUB75 row driver (slave).
interface hub75_row_driver_if #(parameter int NUM_ROWS = led_display_package::GL_NUM_ROWS);
    import led_display_package::*;

    rgb_row_t                      row_in;
    logic                          row_valid_in;
    logic                          row_ready_out;
    logic [$clog2(NUM_ROWS)-1:0]   row_addr_out;
    logic                          frame_start_out;

    modport master (output row_in, row_valid_in,
                    input  row_ready_out, row_addr_out, frame_start_out);
    modport slave  (input  row_in, row_valid_in,
                    output row_ready_out, row_addr_out, frame_start_out);
endinterface

// File: rtl/hub75_row_driver_shifter.sv
// Serialises one captured row pair onto the six HUB75 data lines, MSB pixel first, with a divided shift clock.
module hub75_shifter
    import led_display_package::*;
#(
    parameter int CLK_DIV = 2
)(
    input  logic     clk_in,
    input  logic     n_reset_in,
    input  logic     load,
    input  rgb_row_t row,
    output logic     shift_done,
    output logic     hub_r1,
    output logic     hub_g1,
    output logic     hub_b1,
    output logic     hub_r2,
    output logic     hub_g2,
    output logic     hub_b2,
    output logic     hub_clk
);
    localparam int PW = $clog2(CLK_DIV + 1);
    localparam int XW = $clog2(GL_NUM_COL_PIXELS);

    rgb_row_t        sreg;
    logic            active;
    logic [PW-1:0]   pre;
    logic [XW-1:0]   pix;
    logic            pre_tc;

    assign pre_tc     = (pre == '0);
    assign shift_done = active && pre_tc && hub_clk && (pix == '0);

    // Data flops feed the pins directly; the shift happens on the falling half so data settles before the next rise.
    assign hub_r1 = sreg.top.red[GL_NUM_COL_PIXELS-1];
    assign hub_g1 = sreg.top.green[GL_NUM_COL_PIXELS-1];
    assign hub_b1 = sreg.top.blue[GL_NUM_COL_PIXELS-1];
    assign hub_r2 = sreg.bottom.red[GL_NUM_COL_PIXELS-1];
    assign hub_g2 = sreg.bottom.green[GL_NUM_COL_PIXELS-1];
    assign hub_b2 = sreg.bottom.blue[GL_NUM_COL_PIXELS-1];

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            sreg    <= '0;
            active  <= 1'b0;
            pre     <= '0;
            pix     <= '0;
            hub_clk <= 1'b0;
        end else if (load) begin
            sreg    <= row;
            active  <= 1'b1;
            pre     <= PW'(CLK_DIV - 1);
            pix     <= XW'(GL_NUM_COL_PIXELS - 1);
            hub_clk <= 1'b0;
        end else if (active && pre_tc) begin
            pre     <= PW'(CLK_DIV - 1);
            hub_clk <= !hub_clk;
            if (hub_clk) begin
                sreg <= row_shift_left(sreg);
                if (pix == '0) active <= 1'b0;
                else           pix    <= pix - XW'(1);
            end
        end else if (active) begin
            pre <= pre - PW'(1);
        end
    end
endmodule

// File: rtl/hub75_row_driver.sv
// HUB75 row driver: accepts row pairs, shifts them out, latches with blanking and times the display window.
// Optional macro LED_DISPLAY_BRIGHTNESS_EN adds brightness_in PWM gating of the output enable.
//
// state        | meaning
// IDLE         | ready for the next row pair
// SHIFT        | serialising the captured row
// WAIT_DISP    | shifted row waits for the previous display window to expire
// BLANK_PRE    | output disabled ahead of the latch
// LATCH        | latch pulse, panel address updated
// BLANK_POST   | output disabled after the latch, then new window starts
module hub75_row_driver
    import led_display_package::*;
#(
    parameter int CLK_DIV        = 2,
    parameter int NUM_ROWS       = GL_NUM_ROWS,
    parameter int BLANK_CYCLES   = 4,
    parameter int LATCH_CYCLES   = 2,
    parameter int DISPLAY_CYCLES = 1024
)(
    input  logic                          clk_in,
    input  logic                          n_reset_in,
    hub75_row_driver_if.slave             row_if,
`ifdef LED_DISPLAY_BRIGHTNESS_EN
    input  logic [7:0]                    brightness_in,
`endif
    output logic                          hub_r1_out,
    output logic                          hub_g1_out,
    output logic                          hub_b1_out,
    output logic                          hub_r2_out,
    output logic                          hub_g2_out,
    output logic                          hub_b2_out,
    output logic                          hub_clk_out,
    output logic                          hub_lat_out,
    output logic                          hub_oe_n_out,
    output logic [$clog2(NUM_ROWS)-1:0]   hub_addr_out
);
    localparam int AW = $clog2(NUM_ROWS);
    localparam int DW = $clog2(DISPLAY_CYCLES + 1);
    localparam int TW = $clog2((BLANK_CYCLES > LATCH_CYCLES ? BLANK_CYCLES : LATCH_CYCLES) + 1);
    localparam logic [DW-1:0] DISP_MAX = DW'(DISPLAY_CYCLES);

    hub75_state_t   st, st_nxt;
    logic [TW-1:0]  tmr, tmr_nxt;
    logic [DW-1:0]  disp_cnt, disp_nxt;
    logic [AW-1:0]  row_addr, pend_addr;
    logic           latched, latched_nxt;
    logic           ready_q, frame_start_q;
    logic           accept, enter_latch, post_done, shift_done, oe_en;

    assign row_if.row_ready_out   = ready_q;
    assign row_if.row_addr_out    = row_addr;
    assign row_if.frame_start_out = frame_start_q;

    hub75_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk_in     (clk_in),
        .n_reset_in (n_reset_in),
        .load       (accept),
        .row        (row_if.row_in),
        .shift_done (shift_done),
        .hub_r1     (hub_r1_out),
        .hub_g1     (hub_g1_out),
        .hub_b1     (hub_b1_out),
        .hub_r2     (hub_r2_out),
        .hub_g2     (hub_g2_out),
        .hub_b2     (hub_b2_out),
        .hub_clk    (hub_clk_out)
    );

    always_comb begin
        st_nxt      = st;
        tmr_nxt     = tmr;
        accept      = 1'b0;
        enter_latch = 1'b0;
        post_done   = 1'b0;
        case (st)
            ST_IDLE: begin
                if (row_if.row_valid_in && ready_q) begin
                    accept = 1'b1;
                    st_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (shift_done) st_nxt = ST_WAIT_DISP;
            end
            ST_WAIT_DISP: begin
                if (disp_cnt == DISP_MAX) begin
                    st_nxt  = ST_BLANK_PRE;
                    tmr_nxt = TW'(BLANK_CYCLES - 1);
                end
            end
            ST_BLANK_PRE: begin
                if (tmr == '0) begin
                    st_nxt      = ST_LATCH;
                    tmr_nxt     = TW'(LATCH_CYCLES - 1);
                    enter_latch = 1'b1;
                end else begin
                    tmr_nxt = tmr - TW'(1);
                end
            end
            ST_LATCH: begin
                if (tmr == '0) begin
                    st_nxt  = ST_BLANK_POST;
                    tmr_nxt = TW'(BLANK_CYCLES - 1);
                end else begin
                    tmr_nxt = tmr - TW'(1);
                end
            end
            ST_BLANK_POST: begin
                if (tmr == '0) begin
                    st_nxt    = ST_IDLE;
                    post_done = 1'b1;
                end else begin
                    tmr_nxt = tmr - TW'(1);
                end
            end
            default: st_nxt = ST_IDLE;
        endcase

        if (post_done)                disp_nxt = '0;
        else if (disp_cnt < DISP_MAX) disp_nxt = disp_cnt + DW'(1);
        else                          disp_nxt = disp_cnt;
        latched_nxt = latched || post_done;

        // Enable is evaluated on next-cycle values so the registered pin matches the current state exactly.
        oe_en = latched_nxt && (disp_nxt < DISP_MAX) &&
                !(st_nxt inside {ST_BLANK_PRE, ST_LATCH, ST_BLANK_POST});
`ifdef LED_DISPLAY_BRIGHTNESS_EN
        oe_en = oe_en && (disp_nxt[7:0] < brightness_in);
`endif
    end

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            st            <= ST_IDLE;
            tmr           <= '0;
            disp_cnt      <= DISP_MAX;
            latched       <= 1'b0;
            ready_q       <= 1'b0;
            frame_start_q <= 1'b0;
            row_addr      <= '0;
            pend_addr     <= '0;
            hub_lat_out   <= 1'b0;
            hub_oe_n_out  <= 1'b1;
            hub_addr_out  <= '0;
        end else begin
            st            <= st_nxt;
            tmr           <= tmr_nxt;
            disp_cnt      <= disp_nxt;
            latched       <= latched_nxt;
            ready_q       <= (st_nxt == ST_IDLE);
            frame_start_q <= accept && (row_addr == '0);
            hub_lat_out   <= (st_nxt == ST_LATCH);
            hub_oe_n_out  <= !oe_en;
            if (accept) begin
                pend_addr <= row_addr;
                row_addr  <= (row_addr == AW'(NUM_ROWS - 1)) ? '0 : row_addr + AW'(1);
            end
            if (enter_latch) hub_addr_out <= pend_addr;
        end
    end
endmodule

// File: doc/hub75_row_driver.md
Name: hub75_row_driver

Overview:
- Downstream consumer of the pattern generators' rgb_row_t output; drives the physical HUB75 panel interface.
- Accepts one row pair (top + bottom half) per valid/ready handshake and shifts it out serially on the panel shift clock.
- Latches the shifted row with blanking around the latch, updates the row address, and enables the display window.
- Shifting of the next row overlaps the display window of the previously latched row.

Parameters:
- CLK_DIV, 2, clk_in cycles per half period of hub_clk_out; must be at least 1.
- NUM_ROWS, 16, row pairs per frame; hub_addr_out wraps at NUM_ROWS-1.
- BLANK_CYCLES, 4, clk_in cycles oe_n is held high before and after the latch pulse.
- LATCH_CYCLES, 2, width of the hub_lat_out pulse in clk_in cycles.
- DISPLAY_CYCLES, 1024, length of the display window per latched row, in clk_in cycles.

Ports:
- clk_in, in, 1, system clock.
- n_reset_in, in, 1, reset, asynchronous, active-low.
- row_in, in, rgb_row_t, row pair data; must be stable while row_valid_in is high.
- row_valid_in, in, 1, row_in holds a valid row.
- row_ready_out, out, 1, the driver accepts row_in this cycle.
- row_addr_out, out, $clog2(NUM_ROWS), index of the row pair the driver requests next.
- frame_start_out, out, 1, one-cycle pulse when row 0 is accepted.
- hub_r1_out / hub_g1_out / hub_b1_out, out, 1 each, top-half serial data.
- hub_r2_out / hub_g2_out / hub_b2_out, out, 1 each, bottom-half serial data.
- hub_clk_out, out, 1, panel shift clock.
- hub_lat_out, out, 1, panel latch.
- hub_oe_n_out, out, 1, panel output enable, active-low.
- hub_addr_out, out, $clog2(NUM_ROWS), panel row address.

Behaviour:
- Reset values: row_ready_out=0, row_addr_out=0, frame_start_out=0, all data=0, hub_clk_out=0, hub_lat_out=0, hub_oe_n_out=1, hub_addr_out=0, FSM=IDLE, disp_cnt=DISPLAY_CYCLES (display window expired), no row latched.
- Asserting n_reset_in mid-operation forces all of the above immediately and discards any partial row.
- IDLE:
  - row_ready_out=1.
  - On row_valid_in&&row_ready_out: capture row_in into the shift register, capture row_addr_out as the pending address, pulse frame_start_out if row_addr_out==0, then increment row_addr_out (NUM_ROWS-1 wraps to 0). Next state is SHIFT.
  - row_ready_out is 0 in every other state.
- SHIFT:
  - Pixels go out MSB first (index GL_NUM_COL_PIXELS-1 first).
  - Each pixel: data is driven with hub_clk_out=0 for CLK_DIV cycles, then hub_clk_out=1 for CLK_DIV cycles, so the panel samples on the rising edge.
  - Duration is exactly GL_NUM_COL_PIXELS*2*CLK_DIV cycles. Exit with hub_clk_out=0 to WAIT_DISP.
- WAIT_DISP: hold until disp_cnt==DISPLAY_CYCLES, then go to BLANK_PRE.
- BLANK_PRE: oe_n=1 for BLANK_CYCLES, then go to LATCH.
- LATCH:
  - hub_lat_out=1 for LATCH_CYCLES.
  - hub_addr_out is loaded with the pending address on entry. Next state is BLANK_POST.
- BLANK_POST:
  - oe_n=1 for BLANK_CYCLES. On exit, disp_cnt is cleared to 0, the row is marked latched, and the next state is IDLE.
- Display window:
  - disp_cnt increments while below DISPLAY_CYCLES and saturates there.
  - hub_oe_n_out=0 iff a row is latched, disp_cnt<DISPLAY_CYCLES, and the FSM is not in BLANK_PRE, LATCH or BLANK_POST.
- Upstream stall: if valid is low in IDLE, the window expires and oe_n stays 1. The panel is never displayed longer than DISPLAY_CYCLES per latch.
- Valid held high while ready is low: no capture and no side effects.
- All outputs are registered.

Optional Feature:
- Macro: LED_DISPLAY_BRIGHTNESS_EN.
- With the macro: adds input brightness_in[7:0]. Within the display window, hub_oe_n_out=0 only while disp_cnt[7:0]<brightness_in. brightness_in=0 keeps the panel dark; 0xFF gives 255/256 duty.
- Without the macro: the port is absent and oe_n is low for the entire window.

Decomposition:
- led_display_package holds rgb_row_t, GL_NUM_COL_PIXELS, GL_NUM_ROWS (the default source for NUM_ROWS), and the hub75_state_t enum.
- One sub-module: hub75_shifter, which holds the shift register, the CLK_DIV prescaler and the pixel counter, and reports shift_done. The FSM, timers and address logic stay in the top level.

Test Plan:
- Reset then release with valid=0: oe_n=1, lat=0, clk=0, addr=0, ready=1 held indefinitely.
- One row, top.red=64'h8000_0000_0000_0001, other colours 0, CLK_DIV=2: r1 is 1 at the 1st and 64th rising edges of hub_clk_out only. The row produces 64 rising edges over 256 cycles. The lat pulse is 2 cycles wide, with oe_n high for 4 cycles either side, and hub_addr_out=0 after the latch.
- Continuous valid for 17 rows, NUM_ROWS=16: row_addr_out sequence 0..15,0. frame_start_out pulses at rows 0 and 16. Each latch waits until the previous 1024-cycle window ends, and oe_n low totals 1024 cycles per row.
- Valid dropped for 3000 cycles after the first row: oe_n returns high 1024 cycles after BLANK_POST exit. There are no extra hub_clk_out edges.
- Reset asserted at pixel 30 of SHIFT: outputs are at reset values in the same cycle. After release the next accepted row is row_addr 0 and is shifted completely.
- LED_DISPLAY_BRIGHTNESS_EN defined, brightness_in=8'h40: oe_n low for 64 of every 256 window cycles, 256 cycles total per 1024-cycle window. brightness_in=0 gives oe_n constantly 1.
